// File: rtl/pmem_burst_responder_pkg.sv
// Shared types and constants for the physical-memory line responder:
// line/word widths, beat index type and the responder FSM state encoding.
package pmem_burst_responder_pkg;

    localparam int WORD_W              = 16;
    localparam int LC3B_WORDS_PER_LINE = 8;
    localparam int LINE_W              = WORD_W * LC3B_WORDS_PER_LINE;
    localparam int BEAT_W              = $clog2(LC3B_WORDS_PER_LINE);

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_burst;
    typedef logic [BEAT_W-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BEAT,
        WR_BEAT,
        DONE
    } pmem_resp_state_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(LC3B_WORDS_PER_LINE - 1);

    function automatic lc3b_word sat_inc(input lc3b_word value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pmem_burst_responder_line_buffer.sv
// pmem_line_buffer: one 128-bit line register with full-line load, word-indexed
// load and word-indexed read mux. Used for write-line hold and read-line assembly.
module pmem_line_buffer
    import pmem_burst_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_load,
    input  logic [LINE_W-1:0] line_in,
    input  logic              word_load,
    input  logic [BEAT_W-1:0] word_idx,
    input  logic [WORD_W-1:0] word_in,
    input  logic [BEAT_W-1:0] word_sel,
    output logic [WORD_W-1:0] word_out,
    output logic [LINE_W-1:0] line_out
);

    lc3b_burst line_q;

    // NOTE: this is a flop array, not an SRAM macro, so it can and must be
    // cleared by reset; a real RAM would be left unreset and qualified instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (line_load) begin
            line_q <= line_in;
        end else if (word_load) begin
            line_q[word_idx*WORD_W +: WORD_W] <= word_in;
        end
    end

    assign word_out = line_q[word_sel*WORD_W +: WORD_W];
    assign line_out = line_q;

endmodule

// File: rtl/pmem_burst_responder.sv
// Serialises 128-bit line read/write requests into 8 sequential 16-bit SRAM beats.
// Optional build macro PMEM_PERF_CNT_EN adds saturating completed-line counters.
module pmem_burst_responder
    import pmem_burst_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [WORD_W-1:0] address,
    input  logic [LINE_W-1:0] wdata,
    output logic              resp,
    output logic [LINE_W-1:0] rdata,
    output logic              sram_req,
    output logic              sram_we,
    output logic [WORD_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic              sram_ack,
    input  logic [WORD_W-1:0] sram_rdata
`ifdef PMEM_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] pmem_read_count,
    output logic [WORD_W-1:0] pmem_write_count
`endif
);

    pmem_resp_state_t state_q, state_n;
    beat_idx_t        beat_q, beat_n, beat_next;
    logic [11:0]      base_q, base_n;
    logic             req_n, we_n;
    lc3b_word         addr_n, swd_n;
    logic             accept, rd_store;
    lc3b_word         wr_word;
    lc3b_word         unused_rd_word;
    lc3b_burst        unused_wr_line;
    logic [3:0]       unused_addr_lo;

    assign unused_addr_lo = address[3:0];
    assign beat_next      = beat_q + 1'b1;

    pmem_line_buffer u_wr_line (
        .clk       (clk),
        .rst       (rst),
        .line_load (accept),
        .line_in   (wdata),
        .word_load (1'b0),
        .word_idx  ('0),
        .word_in   ('0),
        .word_sel  (beat_next),
        .word_out  (wr_word),
        .line_out  (unused_wr_line)
    );

    pmem_line_buffer u_rd_line (
        .clk       (clk),
        .rst       (rst),
        .line_load (1'b0),
        .line_in   ('0),
        .word_load (rd_store),
        .word_idx  (beat_q),
        .word_in   (sram_rdata),
        .word_sel  ('0),
        .word_out  (unused_rd_word),
        .line_out  (rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            state_q    <= state_n;
            beat_q     <= beat_n;
            base_q     <= base_n;
            sram_req   <= req_n;
            sram_we    <= we_n;
            sram_addr  <= addr_n;
            sram_wdata <= swd_n;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n  = state_q;
        beat_n   = beat_q;
        base_n   = base_q;
        req_n    = sram_req;
        we_n     = sram_we;
        addr_n   = sram_addr;
        swd_n    = sram_wdata;
        accept   = 1'b0;
        rd_store = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (write || read) begin
                    accept  = 1'b1;
                    state_n = write ? WR_BEAT : RD_BEAT;
                    beat_n  = '0;
                    base_n  = address[15:4];
                    req_n   = 1'b1;
                    we_n    = write;
                    addr_n  = {address[15:4], 4'b0000};
                    swd_n   = wdata[WORD_W-1:0];
                end
            end
            RD_BEAT, WR_BEAT: begin
                // Backend outputs only move on ack, so a stalled beat stays stable.
                if (sram_ack) begin
                    rd_store = (state_q == RD_BEAT);
                    if (beat_q == LAST_BEAT) begin
                        state_n = DONE;
                        req_n   = 1'b0;
                    end else begin
                        beat_n = beat_next;
                        addr_n = {base_q, beat_next, 1'b0};
                        swd_n  = wr_word;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign resp = (state_q == DONE);

`ifdef PMEM_PERF_CNT_EN
    // sram_we still holds the finished transaction's direction while in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_read_count  <= '0;
            pmem_write_count <= '0;
        end else if (state_q == DONE) begin
            if (sram_we) begin
                pmem_write_count <= sat_inc(pmem_write_count);
            end else begin
                pmem_read_count <= sat_inc(pmem_read_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed self-checking bench for pmem_burst_responder with a simple SRAM
// model whose read word is rd_hi plus the word index within the line.
module tb_pmem_burst_responder;

    logic         clk;
    logic         rst;
    logic         read;
    logic         write;
    logic [15:0]  address;
    logic [127:0] wdata;
    logic         resp;
    logic [127:0] rdata;
    logic         sram_req;
    logic         sram_we;
    logic [15:0]  sram_addr;
    logic [15:0]  sram_wdata;
    logic         sram_ack;
    logic [15:0]  sram_rdata;
`ifdef PMEM_PERF_CNT_EN
    logic [15:0]  pmem_read_count;
    logic [15:0]  pmem_write_count;
`endif

    logic         ack_en;
    logic [15:0]  rd_hi;

    int           vectors;
    int           miscompares;

    logic [15:0]  obs_addr [8];
    logic         obs_we   [8];
    logic [15:0]  obs_wd   [8];
    int           obs_n;
    int           resp_cyc;
    logic         hold_ok;
    logic         req_at_resp;

    pmem_burst_responder dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .write      (write),
        .address    (address),
        .wdata      (wdata),
        .resp       (resp),
        .rdata      (rdata),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ack   (sram_ack),
        .sram_rdata (sram_rdata)
`ifdef PMEM_PERF_CNT_EN
        ,
        .pmem_read_count  (pmem_read_count),
        .pmem_write_count (pmem_write_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_ack   = ack_en;
    assign sram_rdata = rd_hi + {13'd0, sram_addr[3:1]};

    // Drives one line request and records each accepted beat, the resp cycle
    // (counted from the accept edge) and whether a stalled beat stayed stable.
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [127:0] wd, input int stall_beat, input int stall_len);
        int          stalled;
        logic [15:0] held_addr;
        stalled     = 0;
        held_addr   = '0;
        obs_n       = 0;
        resp_cyc    = -1;
        hold_ok     = 1'b1;
        req_at_resp = 1'b1;
        @(negedge clk);
        read    = rd;
        write   = wr;
        address = a;
        wdata   = wd;
        ack_en  = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                address = ~a;
                wdata   = ~wd;
            end
            if (resp) begin
                resp_cyc    = cyc;
                req_at_resp = sram_req;
                break;
            end
            if (sram_req) begin
                if (obs_n == stall_beat && stalled < stall_len) begin
                    if (stalled == 0) held_addr = sram_addr;
                    else if (sram_addr !== held_addr) hold_ok = 1'b0;
                    stalled++;
                    ack_en = 1'b0;
                end else begin
                    if (stalled > 0 && obs_n == stall_beat && sram_addr !== held_addr)
                        hold_ok = 1'b0;
                    ack_en = 1'b1;
                    if (obs_n < 8) begin
                        obs_addr[obs_n] = sram_addr;
                        obs_we[obs_n]   = sram_we;
                        obs_wd[obs_n]   = sram_wdata;
                    end
                    obs_n++;
                end
            end
        end
        read   = 1'b0;
        write  = 1'b0;
        ack_en = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({resp, sram_req, sram_we} !== 3'b000 || sram_addr !== 16'h0 || sram_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: resp/req/we=%b addr=%h wdata=%h, required 000/0000/0000",
                     {resp, sram_req, sram_we}, sram_addr, sram_wdata);
        end
        vectors++;
        if (rdata !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h, required 0", rdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read;
        rd_hi = 16'hA000;
        do_txn(1'b1, 1'b0, 16'h1238, 128'h0, -1, 0);
        vectors++;
        if (resp_cyc != 9) begin
            miscompares++;
            $display("FAIL read_resp_cycle: got %0d, required 9", resp_cyc);
        end
        vectors++;
        if (req_at_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL read_req_at_resp: got %b, required 0", req_at_resp);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (obs_addr[k] !== 16'h1230 + 16'(2 * k) || obs_we[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL read_beat%0d: addr=%h we=%b, required %h we=0",
                         k, obs_addr[k], obs_we[k], 16'h1230 + 16'(2 * k));
            end
        end
        vectors++;
        if (rdata !== 128'hA007A006A005A004A003A002A001A000) begin
            miscompares++;
            $display("FAIL read_rdata: got %h, required A007..A000", rdata);
        end
        @(negedge clk);
        vectors++;
        if (resp !== 1'b0 || sram_req !== 1'b0) begin
            miscompares++;
            $display("FAIL read_idle_after: resp=%b req=%b, required 0 0", resp, sram_req);
        end
    endtask

    task automatic test_write;
        logic [127:0] line;
        for (int i = 0; i < 8; i++) line[16*i +: 16] = 16'h0101 * 16'(i);
        do_txn(1'b0, 1'b1, 16'h4000, line, -1, 0);
        vectors++;
        if (resp_cyc != 9 || obs_n != 8) begin
            miscompares++;
            $display("FAIL write_resp: cycle=%0d beats=%0d, required 9 and 8", resp_cyc, obs_n);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs_we[i] !== 1'b1 || obs_wd[i] !== 16'h0101 * 16'(i) ||
                obs_addr[i] !== 16'h4000 + 16'(2 * i)) begin
                miscompares++;
                $display("FAIL write_beat%0d: we=%b wdata=%h addr=%h, required 1 %h %h",
                         i, obs_we[i], obs_wd[i], obs_addr[i],
                         16'h0101 * 16'(i), 16'h4000 + 16'(2 * i));
            end
        end
        vectors++;
        if (rdata !== 128'hA007A006A005A004A003A002A001A000) begin
            miscompares++;
            $display("FAIL write_rdata_kept: got %h, required A007..A000", rdata);
        end
    endtask

    task automatic test_stall;
        rd_hi = 16'hB000;
        do_txn(1'b1, 1'b0, 16'h5550, 128'h0, 4, 3);
        vectors++;
        if (resp_cyc != 12 || obs_n != 8) begin
            miscompares++;
            $display("FAIL stall_resp: cycle=%0d beats=%0d, required 12 and 8", resp_cyc, obs_n);
        end
        vectors++;
        if (hold_ok !== 1'b1 || obs_addr[4] !== 16'h5558) begin
            miscompares++;
            $display("FAIL stall_hold: stable=%b beat4 addr=%h, required 1 5558", hold_ok, obs_addr[4]);
        end
        vectors++;
        if (rdata !== 128'hB007B006B005B004B003B002B001B000) begin
            miscompares++;
            $display("FAIL stall_rdata: got %h, required B007..B000", rdata);
        end
    endtask

    task automatic test_read_write_both;
        int rd_beats;
        do_txn(1'b1, 1'b1, 16'h2000, 128'h7777_6666_5555_4444_3333_2222_1111_0000, -1, 0);
        rd_beats = 0;
        for (int i = 0; i < 8; i++) if (obs_we[i] !== 1'b1) rd_beats++;
        vectors++;
        if (resp_cyc != 9 || rd_beats != 0 || obs_wd[3] !== 16'h3333 || obs_addr[7] !== 16'h200E) begin
            miscompares++;
            $display("FAIL rw_both: cycle=%0d read_beats=%0d w3=%h a7=%h, required 9 0 3333 200E",
                     resp_cyc, rd_beats, obs_wd[3], obs_addr[7]);
        end
        vectors++;
        if (rdata !== 128'hB007B006B005B004B003B002B001B000) begin
            miscompares++;
            $display("FAIL rw_both_rdata: got %h, required B007..B000", rdata);
        end
    endtask

    task automatic test_reset_abort;
        int resp_seen;
        @(negedge clk);
        write   = 1'b1;
        address = 16'h6000;
        wdata   = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
        ack_en  = 1'b1;
        repeat (6) @(negedge clk);
        vectors++;
        if (sram_req !== 1'b1 || sram_addr !== 16'h600A) begin
            miscompares++;
            $display("FAIL abort_beat5: req=%b addr=%h, required 1 600A", sram_req, sram_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (sram_req !== 1'b0 || resp !== 1'b0 || rdata !== 128'h0) begin
            miscompares++;
            $display("FAIL abort_async: req=%b resp=%b rdata=%h, required 0 0 0", sram_req, resp, rdata);
        end
        write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        resp_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp === 1'b1 || sram_req === 1'b1) resp_seen++;
        end
        vectors++;
        if (resp_seen != 0) begin
            miscompares++;
            $display("FAIL abort_no_resp: activity cycles=%0d, required 0", resp_seen);
        end
        rd_hi = 16'hC000;
        do_txn(1'b1, 1'b0, 16'h0010, 128'h0, -1, 0);
        vectors++;
        if (resp_cyc != 9 || rdata !== 128'hC007C006C005C004C003C002C001C000) begin
            miscompares++;
            $display("FAIL abort_next_read: cycle=%0d rdata=%h, required 9 C007..C000", resp_cyc, rdata);
        end
    endtask

    task automatic test_back_to_back;
        int first_cyc;
        int second_cyc;
        first_cyc  = -1;
        second_cyc = -1;
        rd_hi = 16'hD000;
        @(negedge clk);
        read    = 1'b1;
        address = 16'h7770;
        ack_en  = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (resp) begin
                first_cyc = cyc;
                break;
            end
        end
        @(negedge clk);
        vectors++;
        if (first_cyc != 9 || sram_req !== 1'b0 || resp !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: resp cycle=%0d req=%b resp=%b, required 9 0 0", first_cyc, sram_req, resp);
        end
        @(negedge clk);
        vectors++;
        if (sram_req !== 1'b1 || sram_addr !== 16'h7770) begin
            miscompares++;
            $display("FAIL b2b_reaccept: req=%b addr=%h, required 1 7770", sram_req, sram_addr);
        end
        read = 1'b0;
        for (int cyc = 12; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (resp) begin
                second_cyc = cyc;
                break;
            end
        end
        vectors++;
        if (second_cyc != 19 || rdata !== 128'hD007D006D005D004D003D002D001D000) begin
            miscompares++;
            $display("FAIL b2b_second: resp cycle=%0d rdata=%h, required 19 D007..D000", second_cyc, rdata);
        end
    endtask

`ifdef PMEM_PERF_CNT_EN
    task automatic test_perf_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) do_txn(1'b1, 1'b0, 16'h0100, 128'h0, -1, 0);
        for (int i = 0; i < 2; i++) do_txn(1'b0, 1'b1, 16'h0200, 128'h0, -1, 0);
        @(negedge clk);
        vectors++;
        if (pmem_read_count !== 16'd3 || pmem_write_count !== 16'd2) begin
            miscompares++;
            $display("FAIL perf_counts: reads=%0d writes=%0d, required 3 2", pmem_read_count, pmem_write_count);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        read        = 1'b0;
        write       = 1'b0;
        address     = '0;
        wdata       = '0;
        ack_en      = 1'b1;
        rd_hi       = '0;

        test_reset();
        test_read();
        test_write();
        test_stall();
        test_read_write_both();
        test_reset_abort();
        test_back_to_back();
`ifdef PMEM_PERF_CNT_EN
        test_perf_cnt();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
